// File: rtl/uc_microc_if.sv
// Control bundle between uc_microc and the single-cycle datapath.
// master = datapath side (drives start/Opcode/z), slave = control unit.
interface uc_microc_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [5:0]       Opcode;
  logic             z;
  logic             s_inc;
  logic             s_inm;
  logic             we3;
  logic             wez;
  logic [2:0]       Op;
  logic             pc_en;
  logic             z_flag;
  logic             halted;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output start, Opcode, z,
    input  s_inc, s_inm, we3, wez, Op, pc_en, z_flag, halted, instr_count
  );

  modport slave (
    input  start, Opcode, z,
    output s_inc, s_inm, we3, wez, Op, pc_en, z_flag, halted, instr_count
  );
endinterface

// File: rtl/uc_microc.sv
// Control unit for the single-cycle datapath: zero-latency decode in RUN, WAIT stalls
// WAIT_CYCLES extra cycles, HALT parks until reset; no backpressure, pc_en gates the PC.
module uc_microc #(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic        clk,
  input  logic        reset,
  uc_microc_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_WAIT, S_HALT} state_t;

  localparam logic [7:0] STALL_INIT = 8'(WAIT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [7:0]       stall_q;
  logic             z_flag_q;
  logic             halted_q;
  logic [CNT_W-1:0] count_q;

  logic       s_inc, s_inm, we3, wez, pc_en;
  logic [2:0] op;
  logic       is_wait, is_halt;

  assign is_wait = (bus.Opcode[5:2] == 4'b1101);
  assign is_halt = (bus.Opcode == 6'b111111);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.start) state_d = S_RUN;
      S_RUN: begin
        if (is_wait)      state_d = S_WAIT;
        else if (is_halt) state_d = S_HALT;
      end
      S_WAIT:  if (stall_q == 8'd0) state_d = S_RUN;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    s_inc = 1'b1;
    s_inm = 1'b0;
    we3   = 1'b0;
    wez   = 1'b0;
    op    = 3'b000;
    pc_en = 1'b0;
    case (state_q)
      S_RUN: begin
        if (!bus.Opcode[5]) begin
          op    = bus.Opcode[4:2];
          we3   = 1'b1;
          wez   = 1'b1;
          pc_en = 1'b1;
        end else begin
          case (bus.Opcode[4:2])
            3'b000: begin we3 = 1'b1; s_inm = 1'b1; pc_en = 1'b1; end
            3'b001: begin s_inc = 1'b0;      pc_en = 1'b1; end
            // Conditional jumps look only at the registered flag, never live z.
            3'b010: begin s_inc = ~z_flag_q; pc_en = 1'b1; end
            3'b011: begin s_inc = z_flag_q;  pc_en = 1'b1; end
            3'b101: pc_en = 1'b0;
            3'b111: pc_en = ~is_halt;
            default: pc_en = 1'b1;
          endcase
        end
      end
      S_WAIT:  pc_en = (stall_q == 8'd0);
      default: pc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 8'd0;
      z_flag_q <= 1'b0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (state_q == S_RUN && is_wait)
        stall_q <= STALL_INIT;
      else if (state_q == S_WAIT && stall_q != 8'd0)
        stall_q <= stall_q - 8'd1;
      if (wez)
        z_flag_q <= bus.z;
      halted_q <= (state_d == S_HALT);
      if (pc_en)
        count_q <= count_q + 1'b1;
    end
  end

  assign bus.s_inc       = s_inc;
  assign bus.s_inm       = s_inm;
  assign bus.we3         = we3;
  assign bus.wez         = wez;
  assign bus.Op          = op;
  assign bus.pc_en       = pc_en;
  assign bus.z_flag      = z_flag_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_uc_microc.sv
// Bench for uc_microc: stimulus pushes expected outputs from an instruction-level
// model into a queue; a negedge monitor pops and compares every cycle.
module tb_uc_microc;
  localparam int WAIT_CYCLES = 4;
  localparam int CNT_W       = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  uc_microc_if #(.CNT_W(CNT_W)) bus ();

  uc_microc #(.WAIT_CYCLES(WAIT_CYCLES), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef enum {M_IDLE, M_RUN, M_STALL, M_HALT} mode_e;
  typedef enum {K_ALU, K_LI, K_J, K_JZ, K_JNZ, K_WAIT, K_HALT, K_NOP} kind_e;

  typedef struct packed {
    logic             s_inc;
    logic             s_inm;
    logic             we3;
    logic             wez;
    logic [2:0]       op;
    logic             pc_en;
    logic             z_flag;
    logic             halted;
    logic [CNT_W-1:0] count;
  } obs_t;

  obs_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  // Instruction-level model: mode, stall cycles still owed, last ALU zero, retirements.
  mode_e m_mode    = M_IDLE;
  int    m_stall   = 0;
  logic  m_flag    = 1'b0;
  int    m_retired = 0;

  function automatic kind_e classify(input logic [5:0] o);
    if (!o[5])           return K_ALU;
    if (o == 6'b111111)  return K_HALT;
    case (o[5:2])
      4'b1000: return K_LI;
      4'b1001: return K_J;
      4'b1010: return K_JZ;
      4'b1011: return K_JNZ;
      4'b1101: return K_WAIT;
      default: return K_NOP;
    endcase
  endfunction

  task automatic cyc(input logic rs, input logic st, input logic [5:0] opc, input logic zz);
    obs_t  e;
    kind_e k;
    @(posedge clk);
    #1;
    reset      = rs;
    bus.start  = st;
    bus.Opcode = opc;
    bus.z      = zz;
    k = classify(opc);
    if (rs) begin
      m_mode = M_IDLE; m_stall = 0; m_flag = 1'b0; m_retired = 0;
    end
    e = '0;
    e.s_inc = 1'b1;
    if (m_mode == M_RUN) begin
      case (k)
        K_ALU:  begin e.op = opc[4:2]; e.we3 = 1'b1; e.wez = 1'b1; e.pc_en = 1'b1; end
        K_LI:   begin e.we3 = 1'b1; e.s_inm = 1'b1; e.pc_en = 1'b1; end
        K_J:    begin e.s_inc = 1'b0; e.pc_en = 1'b1; end
        K_JZ:   begin e.s_inc = !m_flag; e.pc_en = 1'b1; end
        K_JNZ:  begin e.s_inc = m_flag;  e.pc_en = 1'b1; end
        K_WAIT, K_HALT: e.pc_en = 1'b0;
        default: e.pc_en = 1'b1;
      endcase
    end else if (m_mode == M_STALL) begin
      e.pc_en = (m_stall == 1);
    end
    e.z_flag = m_flag;
    e.halted = (m_mode == M_HALT);
    e.count  = CNT_W'(m_retired);
    exp_q.push_back(e);
    if (!rs) begin
      if (e.pc_en) m_retired++;
      case (m_mode)
        M_IDLE: if (st) m_mode = M_RUN;
        M_RUN: begin
          if (k == K_ALU) m_flag = zz;
          if (k == K_WAIT) begin m_mode = M_STALL; m_stall = WAIT_CYCLES; end
          else if (k == K_HALT) m_mode = M_HALT;
        end
        M_STALL: begin
          m_stall--;
          if (m_stall == 0) m_mode = M_RUN;
        end
        default: ;
      endcase
    end
  endtask

  always @(negedge clk) begin
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.s_inc  = bus.s_inc;
      a.s_inm  = bus.s_inm;
      a.we3    = bus.we3;
      a.wez    = bus.wez;
      a.op     = bus.Op;
      a.pc_en  = bus.pc_en;
      a.z_flag = bus.z_flag;
      a.halted = bus.halted;
      a.count  = bus.instr_count;
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL ctrl_outputs t=%0t op_in=%b got s_inc=%b s_inm=%b we3=%b wez=%b Op=%b pc_en=%b z_flag=%b halted=%b cnt=%0d exp s_inc=%b s_inm=%b we3=%b wez=%b Op=%b pc_en=%b z_flag=%b halted=%b cnt=%0d",
                 $time, bus.Opcode, a.s_inc, a.s_inm, a.we3, a.wez, a.op, a.pc_en, a.z_flag, a.halted, a.count,
                 e.s_inc, e.s_inm, e.we3, e.wez, e.op, e.pc_en, e.z_flag, e.halted, e.count);
      end
    end
  end

  initial begin
    int r;
    logic [5:0] o;
    bus.start  = 1'b0;
    bus.Opcode = 6'b000000;
    bus.z      = 1'b0;

    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    repeat (5) cyc(1'b0, 1'b0, 6'b010100, 1'b0);

    cyc(1'b0, 1'b1, 6'b000000, 1'b0);
    cyc(1'b0, 1'b0, 6'b010100, 1'b1);
    cyc(1'b0, 1'b0, 6'b101000, 1'b0);
    cyc(1'b0, 1'b0, 6'b000100, 1'b0);
    cyc(1'b0, 1'b0, 6'b101000, 1'b1);
    cyc(1'b0, 1'b0, 6'b101100, 1'b1);
    cyc(1'b0, 1'b0, 6'b011000, 1'b1);
    cyc(1'b0, 1'b0, 6'b101100, 1'b0);
    cyc(1'b0, 1'b0, 6'b100011, 1'b0);
    cyc(1'b0, 1'b0, 6'b100101, 1'b1);
    cyc(1'b0, 1'b0, 6'b110010, 1'b1);
    cyc(1'b0, 1'b0, 6'b111110, 1'b0);

    cyc(1'b0, 1'b1, 6'b110100, 1'b0);
    repeat (WAIT_CYCLES) cyc(1'b0, 1'b1, 6'($urandom), 1'($urandom));
    cyc(1'b0, 1'b0, 6'b001000, 1'b0);

    // Reset lands while the stall counter holds 2.
    cyc(1'b0, 1'b0, 6'b011100, 1'b1);
    cyc(1'b0, 1'b0, 6'b110111, 1'b0);
    cyc(1'b0, 1'b0, 6'b000000, 1'b0);
    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    cyc(1'b0, 1'b0, 6'b010000, 1'b1);
    cyc(1'b0, 1'b1, 6'b000000, 1'b0);

    cyc(1'b0, 1'b0, 6'b111111, 1'b0);
    repeat (4) cyc(1'b0, 1'b1, 6'($urandom), 1'($urandom));
    cyc(1'b1, 1'b0, 6'b000000, 1'b0);
    cyc(1'b0, 1'b0, 6'b000000, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2)      o = 6'b111111;
      else if (r < 8) o = {4'b1101, 2'($urandom)};
      else begin
        o = 6'($urandom);
        if (o == 6'b111111) o = 6'b111110;
      end
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), o, 1'($urandom));
    end

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uc_microc.md
# uc_microc

Control unit for the single-cycle microcontroller datapath. Decodes the 6-bit `Opcode` returned by the datapath and drives its control inputs: PC mux select, immediate select, register-file write enable, zero-flag load and ALU operation. Adds run control (start/halt), a multi-cycle WAIT instruction, a registered zero flag for conditional jumps, and a retired-instruction counter. Connects one-to-one with the datapath ports plus a PC load enable (`pc_en`) for the enabled PC register.

## Interface
- `WAIT_CYCLES`, 4: extra stall cycles inserted by WAIT (legal 1..255).
- `CNT_W`, 16: width of retired-instruction counter.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: leaves IDLE; ignored in other states.
- `Opcode` in 6: instruction bits [15:10] from datapath.
- `z` in 1: ALU zero output from datapath (combinational).
- `s_inc` out 1: 1 = PC+1, 0 = jump target.
- `s_inm` out 1: 1 = write immediate to register file, 0 = ALU result.
- `we3` out 1: register-file write enable.
- `wez` out 1: zero-flag load enable.
- `Op` out 3: ALU operation select.
- `pc_en` out 1: PC register load enable.
- `z_flag` out 1: internal registered zero flag.
- `halted` out 1: registered, high in HALT.
- `instr_count` out CNT_W: retired instructions, wraps.

## Operation
- Decode (applies in RUN only):
  - `0ooo xx`: ALU op; Op=Opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1, pc_en=1.
  - `1000 xx` LI: we3=1, s_inm=1, wez=0, s_inc=1, pc_en=1.
  - `1001 xx` J: s_inc=0, pc_en=1.
  - `1010 xx` JZ: s_inc = ~z_flag, pc_en=1.
  - `1011 xx` JNZ: s_inc = z_flag, pc_en=1.
  - `1101 xx` WAIT: pc_en=0, load stall counter with WAIT_CYCLES-1, go WAIT.
  - `111111` HALT: pc_en=0, go HALT.
  - All other codes (incl. `1100 xx`): NOP; s_inc=1, pc_en=1, no writes.
- Defaults when not stated: we3=0, wez=0, s_inm=0, s_inc=1, Op=000.
- FSM states: IDLE, RUN, WAIT, HALT.
  - IDLE: pc_en=0, no writes; start=1 -> RUN next cycle.
  - RUN: decode as above; stays RUN except WAIT/HALT.
  - WAIT: pc_en=0, no writes; counter≠0 -> decrement; counter=0 -> pc_en=1, s_inc=1, go RUN (WAIT retires here).
  - HALT: all enables 0; leaves only via reset.
- z_flag: loads `z` on rising edge when wez=1; otherwise holds. Conditional jumps use the registered value (flag from last ALU op), never the live `z`.
- instr_count: +1 on each edge where pc_en=1; wraps at 2^CNT_W. HALT does not retire.

## Timing
- Reset (async): state=IDLE, z_flag=0, halted=0, instr_count=0, stall counter=0; outputs s_inc=1, s_inm=0, we3=0, wez=0, Op=000, pc_en=0.
- Control outputs are combinational from state, Opcode and z_flag. Zero-latency decode in RUN.
- start asserted in IDLE: first instruction (at PC=0) executes in the cycle after the start edge.
- WAIT occupies WAIT_CYCLES+1 cycles total, PC held throughout.
- ALU op followed by JZ: the JZ sees the flag written by that ALU op (captured at the ALU op's edge).
- start during RUN/WAIT/HALT: no effect.
- reset mid-WAIT or mid-HALT: immediate return to IDLE; counter and flag cleared.
- halted rises the cycle after the HALT opcode is decoded.

## Test plan
- Reset then idle: reset=1 then 0, start=0 for 5 cycles -> pc_en=0, we3=0, s_inc=1, instr_count=0, halted=0.
- ALU decode: start, Opcode=6'b010100 -> Op=3'b101, we3=1, wez=1, s_inm=0, pc_en=1; instr_count +1.
- Flag/jump: ALU op with z=1, next Opcode=JZ (6'b101000) -> s_inc=0; repeat with z=0 -> s_inc=1; JNZ gives the opposite.
- WAIT with WAIT_CYCLES=4: Opcode=6'b110100 -> pc_en=0 for exactly 4 cycles, pc_en=1 on the 5th, instr_count +1.
- HALT: Opcode=6'b111111 -> pc_en=0, halted=1 next cycle and held; start pulses ignored; reset returns to IDLE with halted=0.
- Reset mid-WAIT at stall count 2 -> IDLE immediately, z_flag=0, instr_count=0.
